// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encodings and memory direction codes for the arbiter.
package mem_arbiter_pkg;
  localparam int ARB_STATE_WIDTH = 2;
  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    ARB_STATE_IDLE   = 2'd0,
    ARB_STATE_ACCESS = 2'd1,
    ARB_STATE_ACK    = 2'd2
  } arb_state_e;
  localparam logic MEM_RW_READ  = 1'b1;
  localparam logic MEM_RW_WRITE = 1'b0;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational 2-way round-robin picker; on a tie the port other than last wins.
module rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_valid,
  output logic grant_id
);
  assign grant_valid = req0 | req1;
  assign grant_id    = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between two 4-phase req/ack requesters with
// round-robin conflict resolution and a fixed chip-select latency.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] a0,
  input  logic [DATA_W-1:0] d0,
  output logic              ack0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] a1,
  input  logic [DATA_W-1:0] d1,
  output logic              ack1,
  output logic [DATA_W-1:0] q,
  output logic              mem_cs,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);
  arb_state_e        r_state, w_state_nxt;
  logic              r_ack0, r_ack1, r_cs, r_rw, r_busy, r_win, r_last;
  logic              w_ack0_nxt, w_ack1_nxt, w_cs_nxt, w_rw_nxt, w_busy_nxt, w_win_nxt, w_last_nxt;
  logic [ADDR_W-1:0] r_a, w_a_nxt;
  logic [DATA_W-1:0] r_d, r_q, w_d_nxt, w_q_nxt;
  logic [2:0]        r_lat, w_lat_nxt;
  logic              w_gv, w_gid, w_req_win;

  rr_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last       (r_last),
    .grant_valid(w_gv),
    .grant_id   (w_gid)
  );

  assign w_req_win = r_win ? req1 : req0;

  always_comb begin
    w_state_nxt = r_state;
    w_ack0_nxt  = r_ack0;
    w_ack1_nxt  = r_ack1;
    w_cs_nxt    = r_cs;
    w_rw_nxt    = r_rw;
    w_a_nxt     = r_a;
    w_d_nxt     = r_d;
    w_q_nxt     = r_q;
    w_lat_nxt   = r_lat;
    w_win_nxt   = r_win;
    w_last_nxt  = r_last;
    case (r_state)
      ARB_STATE_IDLE: if (w_gv) begin
        w_state_nxt = ARB_STATE_ACCESS;
        w_cs_nxt    = 1'b1;
        w_rw_nxt    = w_gid ? rw1 : rw0;
        w_a_nxt     = w_gid ? a1 : a0;
        w_d_nxt     = w_gid ? d1 : d0;
        w_lat_nxt   = 3'(MEM_LAT - 1);
        w_win_nxt   = w_gid;
        w_last_nxt  = w_gid;
      end
      ARB_STATE_ACCESS: if (r_lat != 3'd0) begin
        w_lat_nxt = r_lat - 3'd1;
      end else begin
        w_state_nxt = ARB_STATE_ACK;
        w_cs_nxt    = 1'b0;
        w_q_nxt     = (r_rw == MEM_RW_READ) ? mem_q : r_q;
        w_ack0_nxt  = ~r_win;
        w_ack1_nxt  = r_win;
      end
      ARB_STATE_ACK: if (!w_req_win) begin
        w_state_nxt = ARB_STATE_IDLE;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;
      end
      default: begin
        // Corrupted state: recover exactly as if reset had been applied.
        w_state_nxt = ARB_STATE_IDLE;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;
        w_cs_nxt    = 1'b0;
        w_rw_nxt    = MEM_RW_READ;
        w_a_nxt     = '0;
        w_d_nxt     = '0;
        w_q_nxt     = '0;
        w_lat_nxt   = 3'd0;
        w_win_nxt   = 1'b0;
        w_last_nxt  = 1'b1;
      end
    endcase
    w_busy_nxt = w_state_nxt != ARB_STATE_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      r_state <= ARB_STATE_IDLE;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_cs    <= 1'b0;
      r_rw    <= MEM_RW_READ;
      r_a     <= '0;
      r_d     <= '0;
      r_q     <= '0;
      r_lat   <= 3'd0;
      r_win   <= 1'b0;
      r_last  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_cs    <= w_cs_nxt;
      r_rw    <= w_rw_nxt;
      r_a     <= w_a_nxt;
      r_d     <= w_d_nxt;
      r_q     <= w_q_nxt;
      r_lat   <= w_lat_nxt;
      r_win   <= w_win_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign ack0   = r_ack0;
  assign ack1   = r_ack1;
  assign q      = r_q;
  assign mem_cs = r_cs;
  assign mem_rw = r_rw;
  assign mem_a  = r_a;
  assign mem_d  = r_d;
  assign busy   = r_busy;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of handshake timing, round-robin order, latching and reset.
module tb_mem_arbiter;
  logic        clk = 0, res = 0;
  logic        req0 = 0, rw0 = 1, req1 = 0, rw1 = 1;
  logic [7:0]  a0 = 0, a1 = 0;
  logic [15:0] d0 = 0, d1 = 0, mem_q = 0;
  logic        ack0, ack1, mem_cs, mem_rw, busy;
  logic [7:0]  mem_a;
  logic [15:0] q, mem_d;
  logic        req0_b = 0, rw0_b = 1, zero1 = 0;
  logic [7:0]  a0_b = 0, zero8 = 0;
  logic [15:0] mem_q_b = 0, zero16 = 0;
  logic        ack0_b, ack1_b, mem_cs_b, mem_rw_b, busy_b;
  logic [7:0]  mem_a_b;
  logic [15:0] q_b, mem_d_b;
  int checks = 0, failures = 0;

  mem_arbiter #(.DATA_W(16), .ADDR_W(8), .MEM_LAT(1)) u_dut (
    .clk(clk), .res(res),
    .req0(req0), .rw0(rw0), .a0(a0), .d0(d0), .ack0(ack0),
    .req1(req1), .rw1(rw1), .a1(a1), .d1(d1), .ack1(ack1),
    .q(q), .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_a(mem_a), .mem_d(mem_d),
    .mem_q(mem_q), .busy(busy)
  );

  mem_arbiter #(.DATA_W(16), .ADDR_W(8), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .res(res),
    .req0(req0_b), .rw0(rw0_b), .a0(a0_b), .d0(zero16), .ack0(ack0_b),
    .req1(zero1), .rw1(zero1), .a1(zero8), .d1(zero16), .ack1(ack1_b),
    .q(q_b), .mem_cs(mem_cs_b), .mem_rw(mem_rw_b), .mem_a(mem_a_b), .mem_d(mem_d_b),
    .mem_q(mem_q_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_cs", mem_cs, 0);
    check("rst_rw", mem_rw, 1);
    check("rst_a", mem_a, 0);
    check("rst_d", mem_d, 0);
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    res = 1;
    tick();
    check("idle_cs", mem_cs, 0);
    // port 0 read
    req0 = 1; rw0 = 1; a0 = 8'h10; mem_q = 16'hBEEF;
    tick();
    check("rd_cs", mem_cs, 1);
    check("rd_a", mem_a, 8'h10);
    check("rd_rw", mem_rw, 1);
    check("rd_busy", busy, 1);
    check("rd_ack0_early", ack0, 0);
    tick();
    check("rd_cs_off", mem_cs, 0);
    check("rd_ack0", ack0, 1);
    check("rd_q", q, 16'hBEEF);
    check("rd_ack1", ack1, 0);
    tick();
    check("hold_ack0", ack0, 1);
    check("hold_cs", mem_cs, 0);
    tick();
    check("hold_ack0_2", ack0, 1);
    req0 = 0;
    tick();
    check("drop_ack0", ack0, 0);
    check("drop_busy", busy, 0);
    // port 1 write
    req1 = 1; rw1 = 0; a1 = 8'h20; d1 = 16'h1234; mem_q = 16'h5555;
    tick();
    check("wr_cs", mem_cs, 1);
    check("wr_rw", mem_rw, 0);
    check("wr_a", mem_a, 8'h20);
    check("wr_d", mem_d, 16'h1234);
    a1 = 8'h77; d1 = 16'h9999;
    tick();
    check("wr_ack1", ack1, 1);
    check("wr_ack0", ack0, 0);
    check("wr_q_kept", q, 16'hBEEF);
    check("wr_a_latched", mem_a, 8'h20);
    check("wr_d_latched", mem_d, 16'h1234);
    req1 = 0;
    tick();
    check("wr_drop_ack1", ack1, 0);
    // simultaneous requests after reset alternate strictly
    res = 0;
    tick();
    res = 1;
    req0 = 1; rw0 = 1; a0 = 8'h30; req1 = 1; rw1 = 1; a1 = 8'h40;
    tick();
    check("rr1_a", mem_a, 8'h30);
    tick();
    check("rr1_ack0", ack0, 1);
    check("rr1_ack1", ack1, 0);
    req0 = 0;
    tick();
    check("rr1_drop", ack0, 0);
    req0 = 1;
    tick();
    check("rr2_a", mem_a, 8'h40);
    check("rr2_cs", mem_cs, 1);
    tick();
    check("rr2_ack1", ack1, 1);
    check("rr2_ack0", ack0, 0);
    req1 = 0;
    tick();
    check("rr2_drop", ack1, 0);
    tick();
    check("rr3_a", mem_a, 8'h30);
    a0 = 8'h99;
    tick();
    check("rr3_ack0", ack0, 1);
    check("rr3_a_latched", mem_a, 8'h30);
    req0 = 0;
    tick();
    check("rr3_drop", ack0, 0);
    // reset during access
    req0 = 1; a0 = 8'h50;
    tick();
    check("mid_cs", mem_cs, 1);
    res = 0;
    tick();
    check("mid_cs_rst", mem_cs, 0);
    check("mid_ack0_rst", ack0, 0);
    check("mid_ack1_rst", ack1, 0);
    check("mid_busy_rst", busy, 0);
    res = 1;
    tick();
    check("mid_restart_cs", mem_cs, 1);
    check("mid_restart_a", mem_a, 8'h50);
    check("mid_no_stale", ack0, 0);
    tick();
    check("mid_ack0", ack0, 1);
    check("mid_ack1", ack1, 0);
    req0 = 0;
    tick();
    check("mid_drop", ack0, 0);
    // MEM_LAT = 3 read
    req0_b = 1; rw0_b = 1; a0_b = 8'h60; mem_q_b = 16'h1111;
    tick();
    check("l3_cs1", mem_cs_b, 1);
    check("l3_a", mem_a_b, 8'h60);
    tick();
    check("l3_cs2", mem_cs_b, 1);
    check("l3_ack_early", ack0_b, 0);
    tick();
    check("l3_cs3", mem_cs_b, 1);
    check("l3_q_old", q_b, 0);
    mem_q_b = 16'hCAFE;
    tick();
    check("l3_cs_off", mem_cs_b, 0);
    check("l3_ack0", ack0_b, 1);
    check("l3_q", q_b, 16'hCAFE);
    req0_b = 0;
    tick();
    check("l3_drop", ack0_b, 0);
    check("l3_busy", busy_b, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between two requesters: port 0 (instruction fetch) and port 1 (data load/store from the CPU sequencer).
- Each port uses a 4-phase req/ack handshake. Conflicts are resolved round-robin, and memory access is sequenced over a fixed latency.
- Sits between the CPU control/datapath and the memory block, driving memory CS/RW/address/data.

Parameters:
- DATA_W, 16, data bus width; matches `WIDTH.
- ADDR_W, 8, memory address width; matches `RAM_WIDTH.
- MEM_LAT, 1, cycles mem_cs is held per access (1..7); read data is valid at the end of the last cycle.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- res  in  1  reset; synchronous, active-low.
- req0  in  1  port 0 request; held until ack0 is seen high.
- rw0  in  1  port 0 direction: 1 = read, 0 = write.
- a0  in  ADDR_W  port 0 address.
- d0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 acknowledge (4-phase).
- req1/rw1/a1/d1/ack1  same as port 0, for port 1.
- q  out  DATA_W  read data for the acked port; valid while that ack is high.
- mem_cs  out  1  memory chip select.
- mem_rw  out  1  memory direction: 1 = read, 0 = write.
- mem_a  out  ADDR_W  memory address.
- mem_d  out  DATA_W  memory write data.
- mem_q  in  DATA_W  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (res==0 at posedge; res is synchronous only) forces:
  - state=IDLE
  - ack0=ack1=0
  - mem_cs=0, mem_rw=1, mem_a=0, mem_d=0
  - q=0, busy=0
  - last-grant pointer=1, so port 0 wins the first tie.
- States: IDLE, ACCESS, ACK. All outputs are registered.
- IDLE:
  - If any req is high, pick the winner. A single request wins outright; if both are high, the port != last-grant wins.
  - Latch the winner's rw/a/d into mem_rw/mem_a/mem_d; set mem_cs=1.
  - Load lat_cnt=MEM_LAT-1, record the winner id, update last-grant, go to ACCESS.
- ACCESS:
  - mem_cs stays high and the memory outputs stay stable.
  - If lat_cnt!=0, decrement.
  - Else: mem_cs=0; if read, q<=mem_q (on a write q keeps its old value); set ack[winner]=1; go to ACK.
- ACK:
  - ack[winner] stays high until req[winner] is sampled low.
  - Then ack drops and the state returns to IDLE.
  - The other port's request is not examined until IDLE.
- Timing: req rises before edge t (sampled in IDLE) -> mem_cs high for cycles t+1..t+MEM_LAT -> ack high from t+MEM_LAT+1.
- Minimum access period is MEM_LAT+3 cycles, including the req-drop cycle and IDLE.
- The losing request stays pending and is served next; there is no starvation under round-robin.
- A winner's address or data changing after grant is ignored, because the values are latched.
- A req dropped during ACCESS does not abort the access. The ack still rises, then falls the next cycle because req is low.
- Only one ack is ever high at a time; mem_cs is never high outside ACCESS.
- Reset mid-access: the access is abandoned, mem_cs=0 and ack=0 immediately after the edge, and no ack is issued afterwards.
- Illegal state encoding -> IDLE with outputs as at reset.

Decomposition:
- Add to define.v:
  - ARB_STATE_WIDTH=2
  - ARB_STATE_IDLE/ACCESS/ACK encodings
  - MEM_RW_READ=1, MEM_RW_WRITE=0
- Reuse the existing `WIDTH, `RAM_WIDTH, `TRUE and `FALSE.
- One natural sub-module, rr_pick: combinational 2-way round-robin picker (inputs req0, req1, last; outputs grant_valid, grant_id). All other logic stays in mem_arbiter.

Test Plan:
- Reset, then req0=1, rw0=1, a0=8'h10, mem_q=16'hBEEF (MEM_LAT=1) -> mem_cs high for exactly 1 cycle with mem_a=10, mem_rw=1; ack0 rises 2 cycles after the req sample with q=BEEF; ack1 stays 0.
- Port 1 write: rw1=0, a1=8'h20, d1=16'h1234 -> mem_cs with mem_rw=0, mem_a=20, mem_d=1234; ack1 rises; q unchanged.
- req0 and req1 rise in the same cycle after reset -> port 0 is served first. Hold both high and complete the handshakes -> port 1 next, then port 0: strict alternation.
- MEM_LAT=3, read -> mem_cs high for 3 consecutive cycles; q takes mem_q from the 3rd cycle; ack appears on the 4th cycle after the sample.
- Assert reset during ACCESS -> mem_cs=0, ack0=ack1=0, busy=0 on the next edge. Keep req0 high after release -> a fresh access starts, port 0 is granted first, and there is no stale ack.
- Hold req0 high after ack0 -> ack0 stays high and no new access starts. Drop req0 -> ack0 falls one cycle later. Change a0 during ACCESS -> mem_a is unchanged.
